// File: rtl/sop_check_pkg.sv
// Shared definitions for the SOP response checker: FSM encoding and default table/counter sizing.
package sop_check_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_REPORT  = 2'd2;

  localparam logic [7:0] DEF_TRUTH = 8'hE8;
  localparam int         DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_COLLECT = ST_COLLECT,
    S_REPORT  = ST_REPORT
  } state_t;

endpackage

// File: rtl/sop_response_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !(&cnt)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/sop_response_checker.sv
// Checks strobed {vector, output} samples against a truth table, tracking coverage and mismatches.
// Optional idle watchdog enabled by defining SOP_CHECK_TIMEOUT_EN.
module sop_response_checker
  import sop_check_pkg::*;
#(
  parameter int                  N_IN    = 3,
  parameter logic [2**N_IN-1:0]  TRUTH   = DEF_TRUTH,
  parameter int                  CNT_W   = DEF_CNT_W,
  parameter int                  TIMEOUT = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic                 smp_valid,
  input  logic [N_IN-1:0]      smp_vec,
  input  logic                 smp_y,
  output logic [2**N_IN-1:0]   cov_map,
  output logic                 all_cov,
  output logic [CNT_W-1:0]     mismatch_cnt,
  output logic                 first_fail_vld,
  output logic [N_IN-1:0]      first_fail_vec,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout
);

  state_t state;
  logic   accept;
  logic   mis;
  logic   cov_full;
  logic   to_hit;

  // arm wins over a coincident sample, which is dropped
  assign accept   = smp_valid & ~arm & (state == S_COLLECT);
  assign mis      = smp_y != TRUTH[smp_vec];
  assign cov_full = &cov_map;
  assign all_cov  = cov_full;
  assign done     = (state == S_REPORT);

  sat_counter #(.W(CNT_W)) u_mis_cnt (
    .clk (clk),
    .rst (rst),
    .clr (arm),
    .inc (accept & mis),
    .cnt (mismatch_cnt)
  );

`ifdef SOP_CHECK_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] idle_cnt;
  logic            idle_inc;
  logic            timeout_q;

  assign idle_inc = (state == S_COLLECT) & ~accept & ~arm;
  // fire on the edge where the count reaches TIMEOUT; full coverage takes precedence
  assign to_hit   = idle_inc & ~cov_full & (idle_cnt == TO_W'(TIMEOUT - 1));

  sat_counter #(.W(TO_W)) u_idle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (arm | accept | (state != S_COLLECT)),
    .inc (idle_inc),
    .cnt (idle_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else if (arm) begin
      timeout_q <= 1'b0;
    end else if (to_hit) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT > 0);
  assign to_hit             = 1'b0;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      cov_map        <= '0;
      first_fail_vld <= 1'b0;
      first_fail_vec <= '0;
      pass           <= 1'b0;
    end else if (arm) begin
      state          <= S_COLLECT;
      cov_map        <= '0;
      first_fail_vld <= 1'b0;
      first_fail_vec <= '0;
      pass           <= 1'b0;
    end else begin
      if (accept) begin
        cov_map[smp_vec] <= 1'b1;
        if (mis && !first_fail_vld) begin
          first_fail_vld <= 1'b1;
          first_fail_vec <= smp_vec;
        end
      end
      // the completing cycle's own sample still counts toward the verdict
      if (state == S_COLLECT) begin
        if (cov_full) begin
          state <= S_REPORT;
          pass  <= (mismatch_cnt == '0) && !(accept && mis);
        end else if (to_hit) begin
          state <= S_REPORT;
          pass  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sop_response_checker.sv
// Scoreboard bench for sop_response_checker; timeout scenario built when SOP_CHECK_TIMEOUT_EN is defined.
module tb_sop_response_checker;

  localparam logic [7:0] TT = 8'hE8;
  localparam int         TO = 20;

  typedef logic [24:0] snap_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       arm = 1'b0;
  logic       smp_valid = 1'b0;
  logic [2:0] smp_vec = 3'd0;
  logic       smp_y = 1'b0;

  logic [7:0] cov_map;
  logic       all_cov;
  logic [7:0] mismatch_cnt;
  logic       first_fail_vld;
  logic [2:0] first_fail_vec;
  logic       done;
  logic       pass;
  logic       timeout;

  logic [1:0] sat_cnt;
  logic [7:0] sat_unused_cov;
  logic       sat_unused_all;
  logic       sat_unused_ffv;
  logic [2:0] sat_unused_ffvec;
  logic       sat_unused_done;
  logic       sat_unused_pass;
  logic       sat_unused_to;

  snap_t sb_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  logic [7:0] m_cov;
  int         m_cnt;
  logic       m_ffv;
  logic [2:0] m_ffvec;
  int         m_state;
  int         m_idle;
  logic       m_to;

  sop_response_checker #(.N_IN(3), .TRUTH(TT), .CNT_W(8), .TIMEOUT(TO)) u_dut (
    .clk(clk), .rst(rst), .arm(arm), .smp_valid(smp_valid), .smp_vec(smp_vec), .smp_y(smp_y),
    .cov_map(cov_map), .all_cov(all_cov), .mismatch_cnt(mismatch_cnt),
    .first_fail_vld(first_fail_vld), .first_fail_vec(first_fail_vec),
    .done(done), .pass(pass), .timeout(timeout)
  );

  sop_response_checker #(.N_IN(3), .TRUTH(TT), .CNT_W(2), .TIMEOUT(TO)) u_sat (
    .clk(clk), .rst(rst), .arm(arm), .smp_valid(smp_valid), .smp_vec(smp_vec), .smp_y(smp_y),
    .cov_map(sat_unused_cov), .all_cov(sat_unused_all), .mismatch_cnt(sat_cnt),
    .first_fail_vld(sat_unused_ffv), .first_fail_vec(sat_unused_ffvec),
    .done(sat_unused_done), .pass(sat_unused_pass), .timeout(sat_unused_to)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  function automatic snap_t model_snap();
    logic done_e;
    logic pass_e;
    int   sat2;
    done_e = (m_state == 2);
    pass_e = done_e && (m_cnt == 0) && !m_to;
    sat2   = (m_cnt > 3) ? 3 : m_cnt;
    return {m_cov, 8'(m_cnt), m_ffv, m_ffvec, done_e, pass_e, m_to, 2'(sat2)};
  endfunction

  function automatic snap_t dut_snap();
    return {cov_map, mismatch_cnt, first_fail_vld, first_fail_vec, done, pass, timeout, sat_cnt};
  endfunction

  task automatic model_reset();
    m_cov = '0; m_cnt = 0; m_ffv = 1'b0; m_ffvec = '0; m_state = 0; m_idle = 0; m_to = 1'b0;
  endtask

  // Drive one cycle of stimulus, advance the model, push its prediction, sample after the edge.
  task automatic cycle(input logic a, input logic v, input logic [2:0] vec, input logic y);
    logic prev_full;
    @(negedge clk);
    arm = a; smp_valid = v; smp_vec = vec; smp_y = y;
    if (a) begin
      m_cov = '0; m_cnt = 0; m_ffv = 1'b0; m_ffvec = '0; m_state = 1; m_idle = 0; m_to = 1'b0;
    end else if (m_state == 1) begin
      prev_full = (m_cov == 8'hFF);
      if (v) begin
        m_cov[vec] = 1'b1;
        if (y != TT[vec]) begin
          if (m_cnt < 255) m_cnt++;
          if (!m_ffv) begin
            m_ffv = 1'b1;
            m_ffvec = vec;
          end
        end
        m_idle = 0;
      end else begin
        m_idle++;
      end
      if (prev_full) m_state = 2;
`ifdef SOP_CHECK_TIMEOUT_EN
      else if (m_idle == TO) begin
        m_to = 1'b1;
        m_state = 2;
      end
`endif
    end
    sb_q.push_back(model_snap());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    snap_t e, o;
    repeat (2) @(posedge clk);
    #1;
    o = dut_snap();
    vectors++;
    if (o !== '0 || all_cov !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got %h all_cov=%b, want 0", o, all_cov);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle(1'b0, 1'b1, 3'd0, 1'b1);
    e = sb_q.pop_front(); o = dut_snap(); vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL idle_ignore: got %h want %h", o, e);
    end
  endtask

  task automatic test_clean_sweep();
    snap_t e, o;
    cycle(1'b1, 1'b0, 3'd0, 1'b0);
    e = sb_q.pop_front(); o = dut_snap(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL sweep_arm: got %h want %h", o, e); end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 3'(i), TT[i]);
      e = sb_q.pop_front(); o = dut_snap(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL sweep[%0d]: got %h want %h", i, o, e); end
      vectors++;
      if (all_cov !== (i == 7)) begin
        miscompares++;
        $display("FAIL sweep_all_cov[%0d]: got %b want %b", i, all_cov, (i == 7));
      end
    end
    cycle(1'b0, 1'b0, 3'd0, 1'b0);
    e = sb_q.pop_front(); o = dut_snap(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL sweep_report: got %h want %h", o, e); end
    vectors++;
    if ({done, pass, cov_map, mismatch_cnt} !== {1'b1, 1'b1, 8'hFF, 8'd0}) begin
      miscompares++;
      $display("FAIL sweep_verdict: got done=%b pass=%b cov=%h cnt=%0d, want 1 1 ff 0",
               done, pass, cov_map, mismatch_cnt);
    end
  endtask

  task automatic test_faults_duplicate();
    snap_t      e, o;
    logic [2:0] vecs [9] = '{3'd3, 3'd3, 3'd5, 3'd0, 3'd1, 3'd2, 3'd4, 3'd6, 3'd7};
    logic       y;
    cycle(1'b1, 1'b0, 3'd0, 1'b0);
    e = sb_q.pop_front(); o = dut_snap(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL faults_arm: got %h want %h", o, e); end
    for (int i = 0; i < 9; i++) begin
      y = (i < 3) ? 1'b0 : TT[vecs[i]];
      cycle(1'b0, 1'b1, vecs[i], y);
      e = sb_q.pop_front(); o = dut_snap(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL faults[%0d]: got %h want %h", i, o, e); end
    end
    cycle(1'b0, 1'b0, 3'd0, 1'b0);
    e = sb_q.pop_front(); o = dut_snap(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL faults_report: got %h want %h", o, e); end
    vectors++;
    if ({mismatch_cnt, first_fail_vld, first_fail_vec, done, pass} !== {8'd3, 1'b1, 3'd3, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL faults_verdict: got cnt=%0d ffv=%b ffvec=%0d done=%b pass=%b, want 3 1 3 1 0",
               mismatch_cnt, first_fail_vld, first_fail_vec, done, pass);
    end
  endtask

  task automatic test_saturation();
    snap_t e, o;
    cycle(1'b1, 1'b0, 3'd0, 1'b0);
    e = sb_q.pop_front(); o = dut_snap(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL sat_arm: got %h want %h", o, e); end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 3'd0, 1'b1);
      e = sb_q.pop_front(); o = dut_snap(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL sat[%0d]: got %h want %h", i, o, e); end
    end
    vectors++;
    if (sat_cnt !== 2'd3 || mismatch_cnt !== 8'd5) begin
      miscompares++;
      $display("FAIL sat_hold: got sat=%0d cnt=%0d, want 3 5", sat_cnt, mismatch_cnt);
    end
    cycle(1'b1, 1'b1, 3'd2, 1'b1);
    e = sb_q.pop_front(); o = dut_snap(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL collision: got %h want %h", o, e); end
    vectors++;
    if ({sat_cnt, mismatch_cnt, cov_map, first_fail_vld, done} !== '0) begin
      miscompares++;
      $display("FAIL collision_clear: got sat=%0d cnt=%0d cov=%h ffv=%b done=%b, want all 0",
               sat_cnt, mismatch_cnt, cov_map, first_fail_vld, done);
    end
    cycle(1'b0, 1'b1, 3'd1, TT[1]);
    e = sb_q.pop_front(); o = dut_snap(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL collision_collect: got %h want %h", o, e); end
  endtask

  task automatic test_rearm();
    snap_t e, o;
    logic  y;
    cycle(1'b1, 1'b0, 3'd0, 1'b0);
    e = sb_q.pop_front(); o = dut_snap(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL rearm_arm: got %h want %h", o, e); end
    for (int i = 0; i < 9; i++) begin
      y = (i == 6) ? 1'b0 : TT[i % 8];
      cycle(1'b0, (i < 8), 3'(i % 8), y);
      e = sb_q.pop_front(); o = dut_snap(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL rearm_sweep[%0d]: got %h want %h", i, o, e); end
    end
    cycle(1'b1, 1'b0, 3'd0, 1'b0);
    e = sb_q.pop_front(); o = dut_snap(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL rearm_clear: got %h want %h", o, e); end
    vectors++;
    if ({done, mismatch_cnt, first_fail_vld, cov_map} !== '0) begin
      miscompares++;
      $display("FAIL rearm_done_fall: got done=%b cnt=%0d ffv=%b cov=%h, want all 0",
               done, mismatch_cnt, first_fail_vld, cov_map);
    end
  endtask

  task automatic test_midrun_reset();
    snap_t e, o;
    cycle(1'b1, 1'b0, 3'd0, 1'b0);
    e = sb_q.pop_front(); o = dut_snap(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL mid_arm: got %h want %h", o, e); end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 3'(i), (i == 2) ? ~TT[i] : TT[i]);
      e = sb_q.pop_front(); o = dut_snap(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL mid[%0d]: got %h want %h", i, o, e); end
    end
    @(negedge clk);
    arm = 1'b0; smp_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    o = dut_snap(); vectors++;
    if (o !== '0 || all_cov !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got %h all_cov=%b, want 0", o, all_cov);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, 1'b1, 3'd4, 1'b1);
    e = sb_q.pop_front(); o = dut_snap(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL post_reset_idle: got %h want %h", o, e); end
  endtask

  task automatic test_timeout();
    snap_t e, o;
    cycle(1'b1, 1'b0, 3'd0, 1'b0);
    e = sb_q.pop_front(); o = dut_snap(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL to_arm: got %h want %h", o, e); end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 3'(i), TT[i]);
      e = sb_q.pop_front(); o = dut_snap(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL to_vec[%0d]: got %h want %h", i, o, e); end
    end
`ifdef SOP_CHECK_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      cycle(1'b0, 1'b0, 3'd0, 1'b0);
      e = sb_q.pop_front(); o = dut_snap(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL to_idle[%0d]: got %h want %h", k, o, e); end
      if (k == TO - 1) begin
        vectors++;
        if ({timeout, done} !== 2'b00) begin
          miscompares++;
          $display("FAIL to_early: got timeout=%b done=%b, want 0 0", timeout, done);
        end
      end
    end
    vectors++;
    if ({timeout, done, pass, cov_map} !== {1'b1, 1'b1, 1'b0, 8'h0F}) begin
      miscompares++;
      $display("FAIL to_fire: got timeout=%b done=%b pass=%b cov=%h, want 1 1 0 0f",
               timeout, done, pass, cov_map);
    end
`else
    for (int k = 1; k <= 30; k++) begin
      cycle(1'b0, 1'b0, 3'd0, 1'b0);
      e = sb_q.pop_front(); o = dut_snap(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL no_to_idle[%0d]: got %h want %h", k, o, e); end
    end
    vectors++;
    if ({timeout, done, cov_map} !== {1'b0, 1'b0, 8'h0F}) begin
      miscompares++;
      $display("FAIL no_to_hold: got timeout=%b done=%b cov=%h, want 0 0 0f", timeout, done, cov_map);
    end
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_sweep();
    test_faults_duplicate();
    test_saturation();
    test_rearm();
    test_midrun_reset();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
